// File: rtl/arb_req_queue.sv
// Per-requester FIFO bank feeding a round-robin arbiter: queue non-empty flags form the
// request vector, and the acknowledged queue's head is popped and muxed onto data_o.
module arb_req_queue #(
    parameter int unsigned NUM_REQ    = 13,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_i,
    input  logic                                   flush_i,
    input  logic [NUM_REQ-1:0]                     push_valid_i,
    output logic [NUM_REQ-1:0]                     push_ready_o,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]          push_data_i,
    output logic [NUM_REQ-1:0]                     req_o,
    input  logic [NUM_REQ-1:0]                     ack_i,
    input  logic                                   vld_i,
    input  logic [$clog2(NUM_REQ)-1:0]             idx_i,
    output logic [DATA_WIDTH-1:0]                  data_o,
    output logic [NUM_REQ*$clog2(DEPTH+1)-1:0]     cnt_o
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    logic [NUM_REQ-1:0][DATA_WIDTH-1:0] head_data;

    // Explicit wrap so DEPTH need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
    endfunction

    for (genvar k = 0; k < NUM_REQ; k++) begin : g_queue
        logic [DATA_WIDTH-1:0] mem_q [DEPTH];
        logic [PTR_W-1:0]      rd_ptr_q;
        logic [PTR_W-1:0]      rd_ptr_d;
        logic [PTR_W-1:0]      wr_ptr_q;
        logic [PTR_W-1:0]      wr_ptr_d;
        logic [CNT_W-1:0]      cnt_q;
        logic [CNT_W-1:0]      cnt_d;
        logic                  push;
        logic                  pop;

        // Flags come from the count register only, never from ack_i.
        assign push_ready_o[k]          = (cnt_q != CNT_FULL);
        assign req_o[k]                 = (cnt_q != '0);
        assign push                     = push_valid_i[k] & push_ready_o[k];
        assign pop                      = ack_i[k] & req_o[k];
        assign cnt_o[k*CNT_W +: CNT_W]  = cnt_q;
        assign head_data[k]             = mem_q[rd_ptr_q];

        always_comb begin
            rd_ptr_d = rd_ptr_q;
            wr_ptr_d = wr_ptr_q;
            cnt_d    = cnt_q;
            if (flush_i) begin
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                cnt_d    = '0;
            end else begin
                if (push) begin
                    wr_ptr_d = ptr_inc(wr_ptr_q);
                end
                if (pop) begin
                    rd_ptr_d = ptr_inc(rd_ptr_q);
                end
                case ({push, pop})
                    2'b10:   cnt_d = cnt_q + CNT_W'(1);
                    2'b01:   cnt_d = cnt_q - CNT_W'(1);
                    default: cnt_d = cnt_q;
                endcase
            end
        end

        always_ff @(posedge clk_i) begin
            if (rst_i) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
            end else begin
                rd_ptr_q <= rd_ptr_d;
                wr_ptr_q <= wr_ptr_d;
                cnt_q    <= cnt_d;
            end
        end

        // Storage is not reset; a flushed or reset cycle drops the push.
        always_ff @(posedge clk_i) begin
            if (push && !flush_i && !rst_i) begin
                mem_q[wr_ptr_q] <= push_data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    always_comb begin
        data_o = '0;
        if (vld_i && (32'(idx_i) < NUM_REQ)) begin
            data_o = head_data[idx_i];
        end
    end

    // Arbiter interface sanity checks; ack on an empty queue is only reported.
    always @(posedge clk_i) begin
        if (!rst_i) begin
            assert ($onehot0(ack_i))
                else $error("arb_req_queue: ack_i not one-hot or zero (%b)", ack_i);
            if (vld_i) begin
                assert (32'(idx_i) < NUM_REQ)
                    else $error("arb_req_queue: idx_i %0d out of range", idx_i);
                assert ((32'(idx_i) < NUM_REQ) && ack_i[idx_i])
                    else $error("arb_req_queue: vld_i without ack_i[idx_i] (idx %0d ack %b)",
                                idx_i, ack_i);
            end
            if (|(ack_i & ~req_o)) begin
                $warning("arb_req_queue: ack_i %b on empty queue(s), req_o %b", ack_i, req_o);
            end
        end
    end

endmodule

// File: tb/tb_arb_req_queue.sv
// Bench for arb_req_queue: two instances (DEPTH 4 and 3) checked every cycle against a
// queue-based model, plus directed scenarios with hand-computed expectations.
module tb_arb_req_queue;

    localparam int unsigned NR      = 13;
    localparam int unsigned DW      = 32;
    localparam int unsigned IW      = 4;
    localparam int unsigned DEPTH_A = 4;
    localparam int unsigned DEPTH_B = 3;

    logic              clk;
    logic              rst;
    logic              flush;
    logic [NR-1:0]     push_valid;
    logic [NR*DW-1:0]  push_data;
    logic [NR-1:0]     push_ready [2];
    logic [NR-1:0]     req [2];
    logic [NR-1:0]     ack [2];
    logic              vld [2];
    logic [IW-1:0]     idx [2];
    logic [DW-1:0]     dout [2];
    logic [NR*3-1:0]   cnt_a;
    logic [NR*2-1:0]   cnt_b;

    int checks = 0;
    int errors = 0;
    bit started = 1'b0;

    logic [DW-1:0] mq [2*NR][$];

    arb_req_queue #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH_A)) u_dut_a (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready[0]),
        .push_data_i  (push_data),
        .req_o        (req[0]),
        .ack_i        (ack[0]),
        .vld_i        (vld[0]),
        .idx_i        (idx[0]),
        .data_o       (dout[0]),
        .cnt_o        (cnt_a)
    );

    arb_req_queue #(.NUM_REQ(NR), .DATA_WIDTH(DW), .DEPTH(DEPTH_B)) u_dut_b (
        .clk_i        (clk),
        .rst_i        (rst),
        .flush_i      (flush),
        .push_valid_i (push_valid),
        .push_ready_o (push_ready[1]),
        .push_data_i  (push_data),
        .req_o        (req[1]),
        .ack_i        (ack[1]),
        .vld_i        (vld[1]),
        .idx_i        (idx[1]),
        .data_o       (dout[1]),
        .cnt_o        (cnt_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: one SV queue per (instance, requester); pop checked before push so a
    // full queue being popped still refuses the push, as ready is a registered view.
    always @(posedge clk) begin : model
        int q;
        int depth;
        bit rdy;
        if (rst || flush) begin
            for (int i = 0; i < 2*NR; i++) mq[i].delete();
            if (rst) started = 1'b1;
        end else begin
            for (int d = 0; d < 2; d++) begin
                depth = (d == 0) ? DEPTH_A : DEPTH_B;
                for (int k = 0; k < NR; k++) begin
                    q   = d*NR + k;
                    rdy = (mq[q].size() != depth);
                    if (ack[d][k] && mq[q].size() != 0) void'(mq[q].pop_front());
                    if (push_valid[k] && rdy) mq[q].push_back(push_data[k*DW +: DW]);
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        logic [NR-1:0] e_req;
        logic [NR-1:0] e_rdy;
        logic [63:0]   e_cnt;
        logic [63:0]   a_cnt;
        int            depth;
        int            sz;
        int            hq;
        if (started) begin
            for (int d = 0; d < 2; d++) begin
                depth = (d == 0) ? DEPTH_A : DEPTH_B;
                e_req = '0;
                e_rdy = '0;
                e_cnt = '0;
                for (int k = 0; k < NR; k++) begin
                    sz       = mq[d*NR + k].size();
                    e_req[k] = (sz != 0);
                    e_rdy[k] = (sz != depth);
                    if (d == 0) e_cnt[k*3 +: 3] = 3'(sz);
                    else        e_cnt[k*2 +: 2] = 2'(sz);
                end
                a_cnt = (d == 0) ? 64'(cnt_a) : 64'(cnt_b);
                chk($sformatf("req[%0d]", d), 64'(req[d]), 64'(e_req));
                chk($sformatf("push_ready[%0d]", d), 64'(push_ready[d]), 64'(e_rdy));
                chk($sformatf("cnt[%0d]", d), a_cnt, e_cnt);
                if (!vld[d]) begin
                    chk($sformatf("data_idle[%0d]", d), 64'(dout[d]), 64'h0);
                end else if (int'(idx[d]) < NR) begin
                    hq = d*NR + int'(idx[d]);
                    if (mq[hq].size() != 0)
                        chk($sformatf("data_head[%0d]", d), 64'(dout[d]), 64'(mq[hq][0]));
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        push_valid = '0;
        flush      = 1'b0;
        for (int d = 0; d < 2; d++) begin
            ack[d] = '0;
            vld[d] = 1'b0;
            idx[d] = '0;
        end
    endtask

    task automatic set_push(input int k, input logic [DW-1:0] v);
        push_valid[k]         = 1'b1;
        push_data[k*DW +: DW] = v;
    endtask

    task automatic set_pop(input int d, input int k);
        ack[d] = NR'(1) << k;
        vld[d] = 1'b1;
        idx[d] = IW'(k);
    endtask

    task automatic do_flush();
        cyc();
        clear_in();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    // Random arbiter: acks one currently requesting queue, searching from a random start.
    task automatic drive_arb(input int d);
        logic [NR-1:0] r;
        int            start;
        int            j;
        bit            found;
        r      = req[d];
        found  = 1'b0;
        ack[d] = '0;
        vld[d] = 1'b0;
        idx[d] = '0;
        if ($urandom_range(99) < 75) begin
            start = int'($urandom_range(NR-1));
            for (int i = 0; i < NR; i++) begin
                j = (start + i) % NR;
                if (!found && r[j]) begin
                    found = 1'b1;
                    set_pop(d, j);
                end
            end
        end
    endtask

    initial begin : stim
        push_data = '0;
        clear_in();
        rst = 1'b1;
        cyc();
        cyc();
        rst = 1'b0;

        @(negedge clk);
        chk("rst_req", 64'(req[0]), 64'h0);
        chk("rst_ready", 64'(push_ready[0]), 64'h1fff);
        chk("rst_cnt", 64'(cnt_a), 64'h0);
        chk("rst_data", 64'(dout[0]), 64'h0);

        // Single word through queue 3.
        cyc();
        set_push(3, 32'hA5);
        @(negedge clk);
        chk("t1_no_fallthru", 64'(req[0]), 64'h0);
        cyc();
        clear_in();
        set_pop(0, 3);
        @(negedge clk);
        chk("t1_req", 64'(req[0]), 64'h0008);
        chk("t1_cnt3", 64'(cnt_a[9 +: 3]), 64'h1);
        chk("t1_data", 64'(dout[0]), 64'hA5);
        cyc();
        clear_in();
        @(negedge clk);
        chk("t1_req_after", 64'(req[0]), 64'h0);
        chk("t1_cnt3_after", 64'(cnt_a[9 +: 3]), 64'h0);
        do_flush();

        // Fill queue 0, overflow attempt, drain in order.
        for (int i = 1; i <= 4; i++) begin
            set_push(0, DW'(i));
            cyc();
            clear_in();
        end
        set_push(0, 32'h5);
        @(negedge clk);
        chk("t2_full_ready", 64'(push_ready[0][0]), 64'h0);
        chk("t2_full_cnt", 64'(cnt_a[0 +: 3]), 64'h4);
        cyc();
        clear_in();
        @(negedge clk);
        chk("t2_overflow_cnt", 64'(cnt_a[0 +: 3]), 64'h4);
        for (int i = 1; i <= 4; i++) begin
            cyc();
            clear_in();
            set_pop(0, 0);
            @(negedge clk);
            chk($sformatf("t2_pop%0d", i), 64'(dout[0]), 64'(i));
            if (i == 2) chk("t2_ready_back", 64'(push_ready[0][0]), 64'h1);
        end
        do_flush();

        // Simultaneous push and pop on queue 5 at count 2.
        set_push(5, 32'h50);
        cyc();
        clear_in();
        set_push(5, 32'h51);
        cyc();
        clear_in();
        set_push(5, 32'h52);
        set_pop(0, 5);
        @(negedge clk);
        chk("t3_cnt_before", 64'(cnt_a[15 +: 3]), 64'h2);
        chk("t3_data0", 64'(dout[0]), 64'h50);
        cyc();
        clear_in();
        set_pop(0, 5);
        @(negedge clk);
        chk("t3_cnt_same", 64'(cnt_a[15 +: 3]), 64'h2);
        chk("t3_data1", 64'(dout[0]), 64'h51);
        cyc();
        clear_in();
        set_pop(0, 5);
        @(negedge clk);
        chk("t3_data2", 64'(dout[0]), 64'h52);
        chk("t3_cnt_last", 64'(cnt_a[15 +: 3]), 64'h1);
        do_flush();

        // Six words through the DEPTH-3 instance's queue 1 with interleaved pops.
        for (int c = 0; c < 8; c++) begin
            if (c < 6) set_push(1, 32'h100 + DW'(c));
            if (c >= 2) set_pop(1, 1);
            @(negedge clk);
            if (c >= 2) chk($sformatf("t4_data%0d", c - 2), 64'(dout[1]), 64'h100 + 64'(c - 2));
            cyc();
            clear_in();
        end
        @(negedge clk);
        chk("t4_cnt_end", 64'(cnt_b[2 +: 2]), 64'h0);
        do_flush();

        // Flush overrides a push and a pop in the same cycle.
        set_push(2, 32'h20);
        set_push(7, 32'h70);
        cyc();
        clear_in();
        set_push(2, 32'h21);
        set_push(7, 32'h71);
        cyc();
        clear_in();
        flush = 1'b1;
        set_push(2, 32'hDEAD);
        set_pop(0, 7);
        @(negedge clk);
        chk("t5_cnt7_pre", 64'(cnt_a[21 +: 3]), 64'h2);
        cyc();
        clear_in();
        @(negedge clk);
        chk("t5_cnt", 64'(cnt_a), 64'h0);
        chk("t5_req", 64'(req[0]), 64'h0);
        chk("t5_ready", 64'(push_ready[0]), 64'h1fff);
        cyc();
        clear_in();
        set_push(2, 32'h77);
        cyc();
        clear_in();
        set_pop(0, 2);
        @(negedge clk);
        chk("t5_fresh_word", 64'(dout[0]), 64'h77);
        cyc();
        clear_in();

        // Ack on an empty queue must not underflow.
        ack[0] = 13'h0010;
        cyc();
        clear_in();
        @(negedge clk);
        chk("t6_cnt4", 64'(cnt_a[12 +: 3]), 64'h0);
        chk("t6_req", 64'(req[0]), 64'h0);
        cyc();
        clear_in();
        set_push(4, 32'h44);
        cyc();
        clear_in();
        @(negedge clk);
        chk("t6_cnt4_push", 64'(cnt_a[12 +: 3]), 64'h1);
        do_flush();

        // Randomized traffic with alternating fill/drain pressure.
        for (int c = 0; c < 3000; c++) begin
            int pp;
            pp = ((c / 500) % 2 == 0) ? 45 : 8;
            for (int k = 0; k < NR; k++) begin
                push_valid[k]         = ($urandom_range(99) < pp);
                push_data[k*DW +: DW] = $urandom();
            end
            flush = ($urandom_range(199) == 0);
            rst   = ($urandom_range(999) == 0);
            drive_arb(0);
            drive_arb(1);
            cyc();
        end
        rst = 1'b0;
        clear_in();
        cyc();
        cyc();
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/arb_req_queue.md
Name: arb_req_queue

Overview:
- Per-requester FIFO bank that sits directly upstream of the round-robin arbiter.
- Each requester pushes data words into its own queue. The block drives the arbiter's request vector from queue non-empty flags.
- It pops the head of whichever queue the arbiter acknowledges and presents the granted head word on a single output data bus.

Parameters:
- NUM_REQ, 13, number of requesters/queues (>=2); must equal the downstream arbiter's NUM_REQ.
- DATA_WIDTH, 32, width of each queued word.
- DEPTH, 4, entries per queue (>=1, need not be a power of two).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset: synchronous, active-high.
- flush_i  in  1  synchronous clear of all queues.
- push_valid_i  in  NUM_REQ  per-requester push request.
- push_ready_o  out  NUM_REQ  per-requester space available.
- push_data_i  in  NUM_REQ*DATA_WIDTH  flattened push words; requester k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- req_o  out  NUM_REQ  queue non-empty; connects to arbiter req_i.
- ack_i  in  NUM_REQ  arbiter ack_o; one-hot or zero.
- vld_i  in  1  arbiter vld_o.
- idx_i  in  $clog2(NUM_REQ)  arbiter idx_o.
- data_o  out  DATA_WIDTH  head word of queue idx_i.
- cnt_o  out  NUM_REQ*$clog2(DEPTH+1)  flattened per-queue occupancy.

Behaviour:
- Storage and pointers: each queue k has a circular buffer of DEPTH entries, read pointer, write pointer and count register.
  - Pointers wrap from DEPTH-1 to 0 explicitly, so no power-of-two assumption is made.
- Reset (rst_i=1 at a clock edge): all pointers and counts go to 0.
  - After reset: req_o=0, push_ready_o=all ones, cnt_o=0, data_o=0.
  - Storage contents are not reset.
- Flush (flush_i=1, rst_i=0): same effect as reset at that edge.
  - Flush overrides any push or pop in the same cycle; both are dropped.
- push_ready_o[k] = (count_k != DEPTH).
  - Derived from registers only; there is no combinational path from ack_i.
  - A full queue being popped in the same cycle still shows ready=0.
- Push: occurs when push_valid_i[k] and push_ready_o[k] are both 1.
  - The word is written at the write pointer, which then advances.
  - push_valid_i while ready=0 is ignored; the upstream must hold the word.
- req_o[k] = (count_k != 0).
  - No fall-through: a word pushed into an empty queue at edge t raises req_o[k] in the cycle after t, one cycle of latency.
- Pop: occurs when ack_i[k] and req_o[k] are both 1; the read pointer advances.
  - ack_i[k] on an empty queue is ignored; no pointer or count change.
- Count update per queue:
  - push only: +1.
  - pop only: -1.
  - push and pop in the same cycle: count unchanged, both pointers advance. This is legal at any non-full, non-empty level, and at count 0 only as a push (pop is ignored).
- data_o:
  - When vld_i=1: data_o = storage_idx_i[rdptr_idx_i], combinational.
  - When vld_i=0: data_o = 0.
  - The consumer samples data_o in the same cycle as the ack.
- Index and ack roles: pops use ack_i and the mux uses idx_i. The arbiter guarantees ack_i[idx_i]=1 whenever vld_i=1.
- Simulation assertions:
  - ack_i is one-hot or zero.
  - vld_i implies ack_i[idx_i].
  - idx_i < NUM_REQ when vld_i=1.
  - No ack_i[k] while req_o[k]=0. This is a warning only, since the arbiter may be disabled mid-cycle.
- Ordering and independence: each queue is strictly FIFO and queues are independent. Throughput is one push per queue per cycle plus one pop total per cycle.

Test Plan:
1. Reset, then push 0xA5 into queue 3 at cycle 1 → req_o=0x0008 at cycle 2; cnt_o[3]=1. With ack_i=0x0008, vld_i=1, idx_i=3 → data_o=0xA5; next cycle req_o=0, cnt_o[3]=0.
2. Fill queue 0 with 4 words (DEPTH=4) → push_ready_o[0]=0 after the 4th push. A 5th push attempt is ignored. Words pop in order 1,2,3,4, and ready returns to 1 the cycle after the first pop.
3. With queue 5 at count 2, push and ack it in the same cycle → cnt_o[5] stays 2. Subsequent pops return the old head, then the next word, then the newly pushed word.
4. Push 6 words through queue 1 with interleaved pops, DEPTH=3 → pointer wrap exercised; output order matches input order exactly.
5. Queues 2 and 7 each at count 2, assert flush_i together with push_valid_i[2] and ack_i[7] → next cycle all counts are 0, req_o=0, push_ready_o all ones; the pushed word never appears.
6. ack_i=0x0010 with queue 4 empty → no count change, no underflow; cnt_o[4] remains 0.
